// File: rtl/br_pkg.sv
// Shared types and constants for the branch direction predictor.
// Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
package br_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef logic [1:0] bht_ctr_t;

    localparam bht_ctr_t BHT_CTR_INIT = 2'b01;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } br_state_e;

    // Two-bit saturating step toward the observed outcome.
    function automatic bht_ctr_t ctr_next(input bht_ctr_t c, input logic taken);
        bht_ctr_t n;
        n = c;
        if (taken) begin
            if (c != 2'b11) n = c + 2'd1;
        end else begin
            if (c != 2'b00) n = c - 2'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/br_bht.sv
// Branch history table: 2-bit counters, one async read port, one write port.
// The sweep write takes priority over training updates.
module br_bht
    import br_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] i_rd_idx,
    output bht_ctr_t         o_rd_ctr,
    input  logic             i_init_en,
    input  logic [IDX_W-1:0] i_init_idx,
    input  logic             i_upd_en,
    input  logic [IDX_W-1:0] i_upd_idx,
    input  logic             i_upd_taken
);

    bht_ctr_t r_tbl [2**IDX_W];

    assign o_rd_ctr = r_tbl[i_rd_idx];

    // Contents are intentionally not reset; the sweep defines them.
    always_ff @(posedge clk) begin
        if (i_init_en)
            r_tbl[i_init_idx] <= BHT_CTR_INIT;
        else if (i_upd_en)
            r_tbl[i_upd_idx] <= ctr_next(r_tbl[i_upd_idx], i_upd_taken);
    end

endmodule

// File: rtl/br_pred.sv
// Conditional-branch direction predictor with post-reset table sweep.
// Optional gshare indexing enabled by defining BR_PRED_GSHARE_EN.
module br_pred
    import br_pkg::*;
#(
    parameter int BHT_IDX_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [63:0]          pc_f,
    input  logic [31:0]          ir_f,
    output logic                 pr_taken,
    output logic [63:0]          pr_addr,
    output logic [BHT_IDX_W-1:0] pr_idx,
    input  logic                 upd_en,
    input  logic [BHT_IDX_W-1:0] upd_idx,
    input  logic                 upd_taken,
    output logic                 init_busy
);

    br_state_e              r_state;
    logic [BHT_IDX_W-1:0]   r_ptr;
    logic                   w_init_en;
    logic                   w_upd_acc;
    logic                   w_is_br;
    logic [BHT_IDX_W-1:0]   w_idx;
    bht_ctr_t               w_ctr;
    logic [63:0]            w_imm;
    logic                   w_unused_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= INIT;
            r_ptr   <= '0;
        end else if (r_state == INIT) begin
            r_ptr <= r_ptr + 1'b1;
            if (r_ptr == '1) r_state <= RUN;
        end
    end

    assign w_init_en = (r_state == INIT) && !rst;
    assign w_upd_acc = (r_state == RUN) && upd_en && !rst;

`ifdef BR_PRED_GSHARE_EN
    logic [BHT_IDX_W-1:0] r_ghr;

    // History is trained only by resolved branches, so it is non-speculative.
    always_ff @(posedge clk) begin
        if (rst)
            r_ghr <= '0;
        else if (w_upd_acc)
            r_ghr <= {r_ghr[BHT_IDX_W-2:0], upd_taken};
    end

    assign w_idx = pc_f[BHT_IDX_W+1:2] ^ r_ghr;
`else
    assign w_idx = pc_f[BHT_IDX_W+1:2];
`endif

    br_bht #(.IDX_W(BHT_IDX_W)) u_bht (
        .clk         (clk),
        .i_rd_idx    (w_idx),
        .o_rd_ctr    (w_ctr),
        .i_init_en   (w_init_en),
        .i_init_idx  (r_ptr),
        .i_upd_en    (w_upd_acc),
        .i_upd_idx   (upd_idx),
        .i_upd_taken (upd_taken)
    );

    assign w_is_br = (ir_f[6:0] == OP_BRANCH);
    assign w_imm   = {{51{ir_f[31]}}, ir_f[31], ir_f[7], ir_f[30:25], ir_f[11:8], 1'b0};

    assign pr_taken  = w_is_br && (r_state == RUN) && w_ctr[1];
    assign pr_addr   = pr_taken ? (pc_f + w_imm) : (pc_f + 64'd4);
    assign pr_idx    = w_idx;
    assign init_busy = (r_state == INIT);

    assign w_unused_ok = ^{ir_f[24:12], w_ctr[0]};

endmodule

// File: tb/tb_br_pred.sv
// Scoreboard bench for br_pred: stimulus pushes expectations, a negedge monitor checks them.
// Build with +define+BR_PRED_GSHARE_EN to exercise the gshare variant.
module tb_br_pred;

    localparam int W = 6;
    localparam logic [31:0] BEQ_P16 = 32'h0000_0863;
    localparam logic [31:0] BEQ_M8  = 32'hFE00_0CE3;
    localparam logic [31:0] ADDI    = 32'h0010_0093;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [63:0]  pc_f = 64'h0;
    logic [31:0]  ir_f = 32'h0;
    logic         pr_taken;
    logic [63:0]  pr_addr;
    logic [W-1:0] pr_idx;
    logic         upd_en = 1'b0;
    logic [W-1:0] upd_idx = '0;
    logic         upd_taken = 1'b0;
    logic         init_busy;

    br_pred #(.BHT_IDX_W(W)) dut (
        .clk(clk), .rst(rst), .pc_f(pc_f), .ir_f(ir_f),
        .pr_taken(pr_taken), .pr_addr(pr_addr), .pr_idx(pr_idx),
        .upd_en(upd_en), .upd_idx(upd_idx), .upd_taken(upd_taken),
        .init_busy(init_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         tk;
        logic [63:0]  addr;
        logic [W-1:0] idx;
        logic         busy;
    } exp_t;

    exp_t sb[$];
    logic chk = 1'b0;
    int   total = 0;
    int   bad = 0;

    // Monitor: checks the DUT mid-cycle whenever a check is pending.
    always @(negedge clk) begin
        if (chk) begin
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL sb_underflow: no expectation queued");
            end else begin
                exp_t e;
                e = sb.pop_front();
                total++;
                if (pr_taken !== e.tk) begin
                    bad++; $display("FAIL pr_taken t=%0t got=%b exp=%b", $time, pr_taken, e.tk);
                end
                total++;
                if (pr_addr !== e.addr) begin
                    bad++; $display("FAIL pr_addr t=%0t got=%h exp=%h", $time, pr_addr, e.addr);
                end
                total++;
                if (pr_idx !== e.idx) begin
                    bad++; $display("FAIL pr_idx t=%0t got=%0d exp=%0d", $time, pr_idx, e.idx);
                end
                total++;
                if (init_busy !== e.busy) begin
                    bad++; $display("FAIL init_busy t=%0t got=%b exp=%b", $time, init_busy, e.busy);
                end
            end
        end
    end

    task automatic cyc(input logic tk, input logic [63:0] a, input logic [W-1:0] ix, input logic b);
        exp_t e;
        e.tk = tk; e.addr = a; e.idx = ix; e.busy = b;
        sb.push_back(e);
        chk = 1'b1;
        @(posedge clk);
        #1;
        chk = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic busy_cycles(input int n);
        for (int i = 0; i < n; i++)
            cyc(1'b0, pc_f + 64'd4, pc_f[W+1:2], 1'b1);
    endtask

    initial begin
        pc_f = 64'h1000; ir_f = BEQ_P16;
        do_reset();
        // Init window; taken updates to idx 0 here must be dropped.
        for (int i = 0; i < 64; i++) begin
            upd_en = (i >= 10 && i <= 13); upd_idx = '0; upd_taken = 1'b1;
            cyc(1'b0, 64'h1004, 6'd0, 1'b1);
        end
        upd_en = 1'b0;

`ifdef BR_PRED_GSHARE_EN
        cyc(1'b0, 64'h1004, 6'd0, 1'b0);
        // Train idx 7 with T,T,NT: counter 01->10->11->10, GHR -> 110.
        upd_en = 1'b1; upd_idx = 6'd7;
        upd_taken = 1'b1; cyc(1'b0, 64'h1004, 6'd0, 1'b0);
        upd_taken = 1'b1; cyc(1'b0, 64'h1004, 6'd1, 1'b0);
        upd_taken = 1'b0; cyc(1'b0, 64'h1004, 6'd3, 1'b0);
        upd_en = 1'b0;
        cyc(1'b0, 64'h1004, 6'd6, 1'b0);
        pc_f = 64'h1004;
        cyc(1'b1, 64'h1014, 6'd7, 1'b0);
`else
        // Counter 01 after init: not taken.
        cyc(1'b0, 64'h1004, 6'd0, 1'b0);
        // Same-cycle update and predict: pre-update value wins.
        upd_en = 1'b1; upd_idx = 6'd0; upd_taken = 1'b1;
        cyc(1'b0, 64'h1004, 6'd0, 1'b0);
        upd_en = 1'b0;
        cyc(1'b1, 64'h1010, 6'd0, 1'b0);

        // Saturation at idx 5: predictions reflect pre-update counter.
        pc_f = 64'h2014; upd_en = 1'b1; upd_idx = 6'd5; upd_taken = 1'b1;
        cyc(1'b0, 64'h2018, 6'd5, 1'b0);
        cyc(1'b1, 64'h2024, 6'd5, 1'b0);
        cyc(1'b1, 64'h2024, 6'd5, 1'b0);
        cyc(1'b1, 64'h2024, 6'd5, 1'b0);
        cyc(1'b1, 64'h2024, 6'd5, 1'b0);
        upd_taken = 1'b0;
        cyc(1'b1, 64'h2024, 6'd5, 1'b0);
        cyc(1'b1, 64'h2024, 6'd5, 1'b0);
        upd_en = 1'b0;
        cyc(1'b0, 64'h2018, 6'd5, 1'b0);

        // Push idx 0 to 11, then a non-branch must still predict fall-through.
        pc_f = 64'h1000; upd_en = 1'b1; upd_idx = 6'd0; upd_taken = 1'b1;
        cyc(1'b1, 64'h1010, 6'd0, 1'b0);
        upd_en = 1'b0; ir_f = ADDI;
        cyc(1'b0, 64'h1004, 6'd0, 1'b0);

        // Negative offset wrapping below zero.
        pc_f = 64'h0; ir_f = BEQ_M8;
        cyc(1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 6'd0, 1'b0);
`endif

        // Reset during the sweep restarts the full 64-cycle init.
        pc_f = 64'h1000; ir_f = BEQ_P16;
        do_reset();
        busy_cycles(30);
        do_reset();
        busy_cycles(64);
        cyc(1'b0, 64'h1004, 6'd0, 1'b0);

        repeat (2) @(posedge clk);
        if (sb.size() != 0) begin
            total++; bad++;
            $display("FAIL sb_drain: %0d expectations left, 0 required", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
